// File: rtl/div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W variants.
// One quotient bit per cycle; special cases (divide by zero, signed overflow) finish in one cycle.
module div #(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            is_word_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN, S_SPECIAL} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_rem, r_quo, r_div, r_result;
  logic            r_word, r_is_rem, r_neg_q, r_neg_r, r_busy, r_done;

  logic            w_signed, w_a_neg, w_b_neg, w_b_zero, w_ovf, w_special, w_ge;
  logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min, w_spec_val, w_dvd_init;
  logic [XLEN-1:0] w_rem_sh, w_diff, w_q_fix, w_r_fix, w_fin;

  // W ops always sign-extend their 32-bit result, signed or not.
  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    w_signed = ~op[0];
    if (is_word_op) begin
      w_a_ext = {{(XLEN-32){w_signed & a[31]}}, a[31:0]};
      w_b_ext = {{(XLEN-32){w_signed & b[31]}}, b[31:0]};
      w_min   = {{(XLEN-31){1'b1}}, 31'b0};
    end else begin
      w_a_ext = a;
      w_b_ext = b;
      w_min   = {1'b1, {(XLEN-1){1'b0}}};
    end
    w_a_neg   = w_signed & w_a_ext[XLEN-1];
    w_b_neg   = w_signed & w_b_ext[XLEN-1];
    w_a_mag   = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag   = w_b_neg ? -w_b_ext : w_b_ext;
    w_b_zero  = (w_b_ext == '0);
    w_ovf     = w_signed & (w_a_ext == w_min) & (w_b_ext == '1);
    w_special = w_b_zero | w_ovf;
    if (w_b_zero) w_spec_val = op[1] ? w_a_ext : '1;
    else          w_spec_val = op[1] ? '0 : w_a_ext;
    // Word dividends are left-aligned so the same MSB-first shift works for both widths.
    w_dvd_init = is_word_op ? (w_a_mag << 32) : w_a_mag;
  end

  always_comb begin
    w_rem_sh = {r_rem[XLEN-2:0], r_quo[XLEN-1]};
    w_ge     = r_rem[XLEN-1] | (w_rem_sh >= r_div);
    w_diff   = w_rem_sh - r_div;
    w_q_fix  = r_neg_q ? -r_quo : r_quo;
    w_r_fix  = r_neg_r ? -r_rem : r_rem;
    w_fin    = r_is_rem ? w_r_fix : w_q_fix;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = w_special ? S_SPECIAL : S_RUN;
      S_RUN:     if (r_cnt == '0) w_next = S_FIN;
      S_FIN:     w_next = S_IDLE;
      S_SPECIAL: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_result <= '0;
      r_word   <= 1'b0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_busy <= (r_state == S_RUN);
      r_done <= (r_state == S_FIN) || (r_state == S_SPECIAL);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_word   <= is_word_op;
            r_is_rem <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div    <= w_b_mag;
            r_rem    <= '0;
            r_quo    <= w_special ? w_spec_val : w_dvd_init;
            r_cnt    <= is_word_op ? CW'(31) : CW'(XLEN-1);
          end
        end
        S_RUN: begin
          r_rem <= w_ge ? w_diff : w_rem_sh;
          r_quo <= {r_quo[XLEN-2:0], w_ge};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIN:     r_result <= wfix(r_word, w_fin);
        S_SPECIAL: r_result <= wfix(r_word, r_quo);
        default: ;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative integer divider for the CPU execute stage; the inverse companion of the multiplier unit.
- Implements RV64M DIV, DIVU, REM, REMU and the W variants (DIVW, DIVUW, REMW, REMUW).
- Uses a radix-2 restoring algorithm with one quotient bit per cycle.
- A start/done handshake lets the pipeline stall on busy while a division is in flight.

Parameters:
- XLEN, 64, data width. Word ops always operate on 32 bits.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new division. Sampled only when busy=0.
- op  input  2  operation select: 0=DIV, 1=DIVU, 2=REM, 3=REMU. Captured at start.
- is_word_op  input  1  selects the 32-bit W variant. Captured at start.
- a  input  XLEN  dividend. Captured at start.
- b  input  XLEN  divisor. Captured at start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, busy=0, done=0, result=0, all internal registers cleared. A division in progress is abandoned and no done pulse follows.
- States:
  - IDLE: start=1 captures the operands. Next state is SPECIAL if a special case applies, otherwise RUN.
  - RUN: iteration counter counts N-1 down to 0. Each cycle: shift the remainder and quotient left by one, trial-subtract the divisor, set the quotient bit when the result is non-negative.
  - FIN: performs sign fix-up, writes result, pulses done, returns to IDLE.
  - SPECIAL: writes result, pulses done, returns to IDLE.
- N is 64 for dword ops and 32 for word ops.
- Latency, with start accepted at edge T:
  - Normal case: done=1 in cycle T+N+1, i.e. T+65 for dword and T+33 for word.
  - Special cases: done=1 in cycle T+1.
- busy=1 in RUN and FIN. busy=0 in IDLE, including the cycle done is high in IDLE, so back-to-back starts are allowed.
- start while busy=1 is ignored; the operation in flight is unaffected.
- Operand preparation:
  - Word ops take the low 32 bits of each operand. Signed ops sign-extend them; unsigned ops zero-extend them.
  - Signed ops divide magnitudes.
- Sign fix-up for signed ops:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- Special cases, per RISC-V:
  - Divisor zero: quotient = all ones; remainder = dividend.
  - Signed overflow (most-negative / -1): quotient = dividend; remainder = 0.
  - Both are evaluated at the operation width.
- Word results: the 32-bit result is sign-extended to XLEN for all four W ops, including DIVUW and REMUW.
- Dividend of 0 with a non-zero divisor takes the normal path and produces 0.
- No internal pipelining: at most one operation is in flight.

Test Plan:
- DIV: a=0xFFFF_FFFF_FFFF_FFF9 (-7), b=2, start at T -> busy=1 for T+1..T+64, done at T+65, result=0xFFFF_FFFF_FFFF_FFFD (-3). Repeating with REM -> result=0xFFFF_FFFF_FFFF_FFFF (-1).
- DIVU: a=0xFFFF_FFFF_FFFF_FFFF, b=0x10 -> result=0x0FFF_FFFF_FFFF_FFFF at T+65. Repeating with REMU -> result=0xF.
- Divide by zero: DIVU a=5, b=0 -> result=0xFFFF_FFFF_FFFF_FFFF at T+1. REMU -> result=5 at T+1.
- Overflow:
  - DIV a=0x8000_0000_0000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> result=0x8000_0000_0000_0000 at T+1. REM -> result=0.
  - DIVW a=0x0000_0000_8000_0000, b=0xFFFF_FFFF -> result=0xFFFF_FFFF_8000_0000 at T+1.
- Word unsigned: DIVUW a=0x1_FFFF_FFFE, b=1 -> result=0xFFFF_FFFF_FFFF_FFFE at T+33.
- Control:
  - start pulsed at T+10 during a DIV -> ignored; the original result still arrives at T+65.
  - reset asserted at T+20 -> busy, done and result go to 0 immediately, and no done pulse follows.
  - A new start in the done cycle is accepted.
